// File: rtl/input_debouncer_pkg.sv
// Shared types and default build constants for the input debouncer.
// The state encoding is fixed so that Busy is simply the state bit.
package input_debouncer_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  // Defaults sized for a 50 MHz system clock (1 ms stability window)
  localparam int DEFAULT_SYNC_STAGES  = 2;
  localparam int DEFAULT_STABLE_COUNT = 50000;
  localparam int DEFAULT_COUNT_BITS   = 16;

  // True when a CountBits-wide counter can hold StableCount-1 without wrapping
  function automatic bit count_fits(input int bits, input int stable);
    return (64'(1) << bits) > 64'(stable - 1);
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw input plus the conditioned outputs of one debouncer channel.
interface input_debouncer_if;
  logic RawIn;
  logic Level;
  logic LevelBar;
  logic Rise;
  logic Fall;
  logic Busy;

  modport master (output RawIn, input Level, LevelBar, Rise, Fall, Busy);
  modport slave  (input RawIn, output Level, LevelBar, Rise, Fall, Busy);
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// N-deep async-clear shift register for bringing an external signal into Clk.
// Only the last stage is exported; earlier stages may still be metastable.
module sync_chain #(
  parameter int SyncStages = 2
) (
  input  logic Clk,
  input  logic Clr,
  input  logic D,
  output logic Q
);

  logic [SyncStages-1:0] stage_reg;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SyncStages-2:0], D};
    end
  end

  assign Q = stage_reg[SyncStages-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizer, counter-qualified stability filter and edge detect for one
// bouncy input. All outputs are registered; LevelBar is its own flop.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SyncStages  = DEFAULT_SYNC_STAGES,
  parameter int StableCount = DEFAULT_STABLE_COUNT,
  parameter int CountBits   = DEFAULT_COUNT_BITS
) (
  input  logic               Clk,
  input  logic               Clr,
  input_debouncer_if.slave   bus
);

  if (!count_fits(CountBits, StableCount) || SyncStages < 2 || StableCount < 2) begin : g_bad_params
    $error("input_debouncer: illegal SyncStages/StableCount/CountBits combination");
  end

  localparam logic [CountBits-1:0] COUNT_ONE  = CountBits'(1);
  localparam logic [CountBits-1:0] COUNT_LAST = CountBits'(StableCount - 1);

  logic                 sync;
  state_t               state_reg, state_next;
  logic [CountBits-1:0] count_reg, count_next;
  logic                 level_reg, level_next;
  logic                 level_bar_reg, level_bar_next;
  logic                 rise_reg, rise_next;
  logic                 fall_reg, fall_next;
  logic                 busy_reg, busy_next;
  logic                 fire;

  sync_chain #(
    .SyncStages(SyncStages)
  ) u_sync (
    .Clk (Clk),
    .Clr (Clr),
    .D   (bus.RawIn),
    .Q   (sync)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      level_reg     <= 1'b0;
      level_bar_reg <= 1'b1;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      level_reg     <= level_next;
      level_bar_reg <= level_bar_next;
      rise_reg      <= rise_next;
      fall_reg      <= fall_next;
      busy_reg      <= busy_next;
    end
  end

  // A bounce back to the current level discards all accumulated credit
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (sync != level_reg) begin
          state_next = COUNTING;
          count_next = COUNT_ONE;
        end
      end
      COUNTING: begin
        if (sync == level_reg || count_reg == COUNT_LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + COUNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    fire           = (state_reg == COUNTING) && (sync != level_reg) && (count_reg == COUNT_LAST);
    level_next     = fire ? sync  : level_reg;
    level_bar_next = fire ? ~sync : level_bar_reg;
    rise_next      = fire & sync;
    fall_next      = fire & ~sync;
    busy_next      = (state_next == COUNTING);
  end

  assign bus.Level    = level_reg;
  assign bus.LevelBar = level_bar_reg;
  assign bus.Rise     = rise_reg;
  assign bus.Fall     = fall_reg;
  assign bus.Busy     = busy_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios with literal expectations plus
// randomized bursts, all checked every cycle against a sample-history model.
module tb_input_debouncer;

  localparam int S = 2;
  localparam int N = 4;
  localparam int B = 3;
  localparam int HIST = 8192;

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  bit   check_en = 1'b0;

  input_debouncer_if bus ();

  input_debouncer #(
    .SyncStages  (S),
    .StableCount (N),
    .CountBits   (B)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: raw_hist[k] is RawIn sampled at edge k since reset release. The
  // filter sees raw_hist[k-S] at edge k. Level flips at edge n when the last N
  // filter samples all differ from Level and none predates the previous flip.
  bit raw_hist [HIST];
  int n;
  int m_last_change;
  bit m_level, m_rise, m_fall, m_busy;

  function automatic bit seen(input int k);
    return (k - S >= 1) ? raw_hist[k - S] : 1'b0;
  endfunction

  always @(posedge Clk or posedge Clr) begin
    bit q;
    int k;
    if (Clr) begin
      n             = 0;
      m_last_change = 0;
      m_level       = 1'b0;
      m_rise        = 1'b0;
      m_fall        = 1'b0;
      m_busy        = 1'b0;
    end else begin
      if (n < HIST - 1) n++;
      raw_hist[n] = bus.RawIn;
      q = 1'b1;
      for (int j = 0; j < N; j++) begin
        k = n - j;
        if (k <= m_last_change || seen(k) == m_level) q = 1'b0;
      end
      if (q) begin
        m_level       = ~m_level;
        m_rise        = m_level;
        m_fall        = ~m_level;
        m_busy        = 1'b0;
        m_last_change = n;
      end else begin
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = (seen(n) != m_level);
      end
    end
  end

  always @(negedge Clk) begin
    if (check_en) begin
      check("model_level",    bus.Level,    m_level);
      check("model_levelbar", bus.LevelBar, ~m_level);
      check("model_rise",     bus.Rise,     m_rise);
      check("model_fall",     bus.Fall,     m_fall);
      check("model_busy",     bus.Busy,     m_busy);
    end
  end

  initial begin
    int rise_count;
    int rise_edge;
    int val;
    int dur;

    bus.RawIn = 1'b0;
    Clr = 1'b1;
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    check_en = 1'b1;
    repeat (3) @(negedge Clk);

    // Clean rise
    bus.RawIn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      check("rise_busy",  bus.Busy,  (k >= 3 && k <= 5));
      check("rise_level", bus.Level, (k >= 6));
      check("rise_pulse", bus.Rise,  (k == 6));
    end
    $display("clean rise done, Level=%b", bus.Level);

    // Clean fall
    @(negedge Clk);
    bus.RawIn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      check("fall_levelbar", bus.LevelBar, (k >= 6));
      check("fall_pulse",    bus.Fall,     (k == 6));
      check("fall_norise",   bus.Rise,     1'b0);
    end
    $display("clean fall done, Level=%b", bus.Level);

    // Glitch of three edges must be rejected
    @(negedge Clk);
    bus.RawIn = 1'b1;
    repeat (3) @(negedge Clk);
    bus.RawIn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      check("glitch_level", bus.Level, 1'b0);
      check("glitch_rise",  bus.Rise,  1'b0);
    end
    check("glitch_busy_end", bus.Busy, 1'b0);
    $display("glitch reject done, Level=%b", bus.Level);

    // Bounce: toggle every cycle, then settle high
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      bus.RawIn = ~bus.RawIn;
    end
    @(negedge Clk);
    bus.RawIn  = 1'b1;
    rise_count = 0;
    rise_edge  = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      if (bus.Rise) begin
        rise_count++;
        rise_edge = k;
      end
    end
    check_int("bounce_rise_count", rise_count, 1);
    check_int("bounce_rise_edge",  rise_edge,  6);
    $display("bounce done, rises=%0d at edge %0d", rise_count, rise_edge);

    // Asynchronous reset mid-cycle with Level=1 and RawIn=1
    @(posedge Clk); #2;
    Clr = 1'b1;
    #1;
    check("areset_level",    bus.Level,    1'b0);
    check("areset_levelbar", bus.LevelBar, 1'b1);
    check("areset_rise",     bus.Rise,     1'b0);
    check("areset_fall",     bus.Fall,     1'b0);
    check("areset_busy",     bus.Busy,     1'b0);
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    $display("async reset done");

    // Reset during qualification (Count=2), then release with RawIn still 1
    repeat (4) @(posedge Clk);
    #1;
    check("midcount_busy", bus.Busy, 1'b1);
    #1;
    Clr = 1'b1;
    #1;
    check("midcount_busy_clr", bus.Busy, 1'b0);
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      check("release_rise",  bus.Rise,  (k == 6));
      check("release_level", bus.Level, (k >= 6));
    end
    $display("reset mid-count done, Level=%b", bus.Level);

    // Randomized bursts with occasional asynchronous resets
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(posedge Clk); #3;
        Clr = 1'b1;
        @(negedge Clk);
        if ($urandom_range(0, 1) == 1) @(negedge Clk);
        Clr = 1'b0;
        $display("burst %0d: reset pulse", t);
      end else begin
        val = $urandom_range(0, 1);
        dur = $urandom_range(1, 9);
        @(negedge Clk);
        bus.RawIn = val[0];
        repeat (dur - 1) @(negedge Clk);
        $display("burst %0d: RawIn=%0d for %0d cycles, Level=%b", t, val, dur, bus.Level);
      end
    end
    repeat (10) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
